// File: rtl/antifurto_pkg.sv
// Shared definitions for the anti-theft timer: interval codes, default
// parameter values and the countdown state encoding.
package antifurto_pkg;

    localparam logic [1:0] INT_ARM       = 2'b00;
    localparam logic [1:0] INT_DRIVER    = 2'b01;
    localparam logic [1:0] INT_PASSENGER = 2'b10;
    localparam logic [1:0] INT_ALARM     = 2'b11;

    localparam int unsigned DEF_ARM       = 6;
    localparam int unsigned DEF_DRIVER    = 8;
    localparam int unsigned DEF_PASSENGER = 15;
    localparam int unsigned DEF_ALARM     = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_EXPIRE = 2'd2
    } timer_state_e;

endpackage

// File: rtl/divisor_1hz.sv
// Free-running prescaler producing a one-cycle tick every CLK_FREQ cycles;
// a synchronous clear restarts the phase from zero.
module divisor_1hz #(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned DW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_FREQ - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (clear || div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = (div_q == DIV_LAST);

endmodule

// File: rtl/timer_antifurto.sv
// Countdown timer for the anti-theft FSM: reprogrammable parameter file,
// whole-second countdown driven by the 1 Hz prescaler, one-cycle expiry pulse.
module timer_antifurto
    import antifurto_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned VAL_W         = 4,
    parameter int unsigned DEF_ARM       = antifurto_pkg::DEF_ARM,
    parameter int unsigned DEF_DRIVER    = antifurto_pkg::DEF_DRIVER,
    parameter int unsigned DEF_PASSENGER = antifurto_pkg::DEF_PASSENGER,
    parameter int unsigned DEF_ALARM     = antifurto_pkg::DEF_ALARM
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_timer,
    input  logic [1:0]       interval,
    input  logic             reprogram,
    input  logic [1:0]       time_param_sel,
    input  logic [VAL_W-1:0] time_value,
    output logic             expired,
    output logic             one_hz_enable,
    output logic [VAL_W-1:0] seconds_left,
    output logic             busy
);

    timer_state_e     state_q, state_d;
    logic [VAL_W-1:0] cnt_q, cnt_d;
    logic [VAL_W-1:0] param_q [4];
    logic [VAL_W-1:0] param_d [4];
    logic [VAL_W-1:0] load_val;
    logic             tick;

    divisor_1hz #(
        .CLK_FREQ(CLK_FREQ)
    ) u_div (
        .clock(clock),
        .reset(reset),
        .clear(start_timer),
        .tick (tick)
    );

    // Load reads the registered parameter, so a same-edge reprogram is not seen.
    assign load_val = param_q[interval];

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            param_d[i] = param_q[i];
        end
        if (reprogram) begin
            param_d[time_param_sel] = time_value;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start_timer) begin
            cnt_d   = load_val;
            state_d = (load_val != '0) ? ST_RUN : ST_EXPIRE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (tick) begin
                        if (cnt_q == VAL_W'(1)) begin
                            cnt_d   = '0;
                            state_d = ST_EXPIRE;
                        end else begin
                            cnt_d = cnt_q - VAL_W'(1);
                        end
                    end
                end
                ST_EXPIRE: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q                 <= ST_IDLE;
            cnt_q                   <= '0;
            param_q[INT_ARM]        <= VAL_W'(DEF_ARM);
            param_q[INT_DRIVER]     <= VAL_W'(DEF_DRIVER);
            param_q[INT_PASSENGER]  <= VAL_W'(DEF_PASSENGER);
            param_q[INT_ALARM]      <= VAL_W'(DEF_ALARM);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int unsigned i = 0; i < 4; i++) begin
                param_q[i] <= param_d[i];
            end
        end
    end

    assign expired       = (state_q == ST_EXPIRE);
    assign busy          = (state_q == ST_RUN);
    assign seconds_left  = cnt_q;
    assign one_hz_enable = tick;

endmodule

// File: tb/tb_timer_antifurto.sv
// Bench for timer_antifurto: directed scenarios plus random traffic, checked
// every cycle against an arithmetic model based on edge counts since load.
module tb_timer_antifurto;

    localparam int CF = 4;
    localparam int VW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          start_timer;
    logic [1:0]    interval;
    logic          reprogram;
    logic [1:0]    time_param_sel;
    logic [VW-1:0] time_value;
    logic          expired;
    logic          one_hz_enable;
    logic [VW-1:0] seconds_left;
    logic          busy;

    int vectors    = 0;
    int miscompares = 0;

    // Model: edge counter, phase origin, last load edge and loaded value.
    int e;
    int p;
    int l;
    int n;
    bit act;
    int prm [4];

    always #5 clock = ~clock;

    timer_antifurto #(
        .CLK_FREQ(CF),
        .VAL_W   (VW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start_timer   (start_timer),
        .interval      (interval),
        .reprogram     (reprogram),
        .time_param_sel(time_param_sel),
        .time_value    (time_value),
        .expired       (expired),
        .one_hz_enable (one_hz_enable),
        .seconds_left  (seconds_left),
        .busy          (busy)
    );

    task automatic model_reset();
        e   = 0;
        p   = 0;
        l   = 0;
        n   = 0;
        act = 1'b0;
        prm[0] = 6;
        prm[1] = 8;
        prm[2] = 15;
        prm[3] = 10;
    endtask

    task automatic check(input string tag);
        bit x_exp;
        bit x_busy;
        bit x_hz;
        int x_left;
        int el;
        x_exp  = 1'b0;
        x_busy = 1'b0;
        x_left = 0;
        x_hz   = (((e - p) % CF) == CF - 1);
        if (act) begin
            el = e - l;
            if (el < CF * n) begin
                x_busy = 1'b1;
                x_left = n - el / CF;
            end else if (el == CF * n) begin
                x_exp = 1'b1;
            end
        end
        vectors += 4;
        assert (expired === x_exp) else begin
            miscompares++;
            $error("FAIL %s expired got %0b want %0b (edge %0d)", tag, expired, x_exp, e);
        end
        assert (busy === x_busy) else begin
            miscompares++;
            $error("FAIL %s busy got %0b want %0b (edge %0d)", tag, busy, x_busy, e);
        end
        assert (seconds_left === VW'(x_left)) else begin
            miscompares++;
            $error("FAIL %s seconds_left got %0d want %0d (edge %0d)", tag, seconds_left, x_left, e);
        end
        assert (one_hz_enable === x_hz) else begin
            miscompares++;
            $error("FAIL %s one_hz_enable got %0b want %0b (edge %0d)", tag, one_hz_enable, x_hz, e);
        end
    endtask

    task automatic step(input bit st, input logic [1:0] iv, input bit rp,
                        input logic [1:0] sl, input logic [VW-1:0] v, input string tag);
        start_timer    = st;
        interval       = iv;
        reprogram      = rp;
        time_param_sel = sl;
        time_value     = v;
        @(posedge clock);
        e++;
        if (st) begin
            n   = prm[iv];
            l   = e;
            p   = e;
            act = 1'b1;
        end
        if (rp) prm[sl] = int'(v);
        #1;
        start_timer = 1'b0;
        reprogram   = 1'b0;
        check(tag);
    endtask

    task automatic idle(input int k, input string tag);
        for (int i = 0; i < k; i++) step(1'b0, 2'b00, 1'b0, 2'b00, '0, tag);
    endtask

    initial begin
        reset          = 1'b1;
        start_timer    = 1'b0;
        interval       = '0;
        reprogram      = 1'b0;
        time_param_sel = '0;
        time_value     = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset");
        #3 reset = 1'b0;

        // Driver delay 8 s: full countdown and single expiry pulse.
        step(1'b1, 2'b01, 1'b0, 2'b00, '0, "t1_load");
        idle(36, "t1_run");

        // Reprogram passenger to 3, load it, then confirm driver still 8.
        step(1'b0, 2'b00, 1'b1, 2'b10, 4'd3, "t2_rep");
        step(1'b1, 2'b10, 1'b0, 2'b00, '0, "t2_load");
        idle(14, "t2_run");
        step(1'b1, 2'b01, 1'b0, 2'b00, '0, "t2_drv");
        idle(34, "t2_drv_run");

        // Restart mid-count abandons the alarm countdown.
        step(1'b1, 2'b11, 1'b0, 2'b00, '0, "t3_load1");
        idle(8, "t3_run1");
        step(1'b1, 2'b00, 1'b0, 2'b00, '0, "t3_load2");
        idle(45, "t3_run2");

        // Zero parameter expires immediately.
        step(1'b0, 2'b00, 1'b1, 2'b00, 4'd0, "t4_rep");
        step(1'b1, 2'b00, 1'b0, 2'b00, '0, "t4_load");
        idle(4, "t4_after");

        // Idle prescaler, then a load at a random phase realigns it.
        idle(9, "t6_idle");
        idle(int'($urandom_range(0, 3)), "t6_phase");
        step(1'b1, 2'b11, 1'b0, 2'b00, '0, "t6_load");
        idle(10, "t6_run");

        // Same-edge reprogram and load uses the old value.
        step(1'b1, 2'b01, 1'b1, 2'b01, 4'd2, "t7_load");
        idle(34, "t7_run");
        step(1'b1, 2'b01, 1'b0, 2'b00, '0, "t7_reload");
        idle(10, "t7_rerun");

        // Asynchronous reset in the middle of a count.
        step(1'b1, 2'b01, 1'b0, 2'b00, '0, "t5_load");
        idle(12, "t5_run");
        reset = 1'b1;
        #2;
        model_reset();
        check("t5_async_rst");
        #2 reset = 1'b0;
        step(1'b1, 2'b10, 1'b0, 2'b00, '0, "t5_pass");
        idle(62, "t5_run2");

        // Random traffic, including held starts and reprogram during RUN.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 14) == 0), 2'($urandom), ($urandom_range(0, 9) == 0),
                 2'($urandom), 4'($urandom), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
